// File: rtl/fir_coeff_sequencer.sv
// Stages four coefficient words, clears/writes/reads back the selected FIR filters, then re-arms the trigger.
// Coefficient-port outputs are registered; valid_gate stays low from start until a clean sequence ends.
module fir_coeff_sequencer #(
    parameter int CLR_LEN    = 4,
    parameter int RD_TIMEOUT = 16,
    parameter int SETTLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stage_we,
    input  logic [1:0]  stage_adr,
    input  logic [63:0] stage_data,
    input  logic        start,
    input  logic [3:0]  filt_mask,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [1:0]  err_filt,
    output logic [1:0]  err_adr,
    output logic        valid_gate,
    output logic        bsum_reset,
    output logic        coeff_areset,
    output logic [3:0]  coeff_we,
    output logic [1:0]  coeff_adr,
    output logic [63:0] coeff_data,
    output logic        coeff_read,
    input  logic [3:0]  coeff_valid,
    input  logic [63:0] coeff_rdata
);
    localparam int CNT_MAX = (SETTLE_LEN > RD_TIMEOUT)
                           ? ((SETTLE_LEN > CLR_LEN) ? SETTLE_LEN : CLR_LEN)
                           : ((RD_TIMEOUT > CLR_LEN) ? RD_TIMEOUT : CLR_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_WRITE, S_RD, S_WAIT, S_BSRST, S_SETTLE, S_DONE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         filt_q, filt_d;
    logic [1:0]         first_q, first_d;
    logic [1:0]         widx_q, widx_d;
    logic [3:0]         mask_q, mask_d;
    logic [63:0]        stage_q [4];
    logic [63:0]        stage_d [4];
    logic [63:0]        snap_q [4];
    logic [63:0]        snap_d [4];
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [1:0]         err_filt_q, err_filt_d;
    logic [1:0]         err_adr_q, err_adr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_gate_q, valid_gate_d;
    logic               bsum_reset_q, bsum_reset_d;
    logic               coeff_areset_q, coeff_areset_d;
    logic [3:0]         coeff_we_q, coeff_we_d;
    logic [1:0]         coeff_adr_q, coeff_adr_d;
    logic [63:0]        coeff_data_q, coeff_data_d;
    logic               coeff_read_q, coeff_read_d;
    logic [2:0]         first_s;
    logic [2:0]         next_s;

    // Lowest set mask bit at or above 'from'; bit 2 of the result flags "none left".
    function automatic logic [2:0] seek(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) begin
                r = {1'b0, 2'(i)};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            filt_q         <= '0;
            first_q        <= '0;
            widx_q         <= '0;
            mask_q         <= '0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
            err_filt_q     <= '0;
            err_adr_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            valid_gate_q   <= 1'b1;
            bsum_reset_q   <= 1'b0;
            coeff_areset_q <= 1'b0;
            coeff_we_q     <= '0;
            coeff_adr_q    <= '0;
            coeff_data_q   <= '0;
            coeff_read_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= '0;
                snap_q[i]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            filt_q         <= filt_d;
            first_q        <= first_d;
            widx_q         <= widx_d;
            mask_q         <= mask_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            err_filt_q     <= err_filt_d;
            err_adr_q      <= err_adr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            valid_gate_q   <= valid_gate_d;
            bsum_reset_q   <= bsum_reset_d;
            coeff_areset_q <= coeff_areset_d;
            coeff_we_q     <= coeff_we_d;
            coeff_adr_q    <= coeff_adr_d;
            coeff_data_q   <= coeff_data_d;
            coeff_read_q   <= coeff_read_d;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= stage_d[i];
                snap_q[i]  <= snap_d[i];
            end
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (stage_we && !busy_q) begin
            stage_d[stage_adr] = stage_data;
        end
    end

    // The sequence works from a snapshot so a staging write in the start cycle does not leak in.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        filt_d     = filt_q;
        first_d    = first_q;
        widx_d     = widx_q;
        mask_d     = mask_q;
        snap_d     = snap_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_filt_d = err_filt_q;
        err_adr_d  = err_adr_q;
        first_s    = seek(filt_mask, 3'd0);
        next_s     = seek(mask_q, {1'b0, filt_q} + 3'd1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d     = filt_mask;
                    snap_d     = stage_q;
                    err_d      = 1'b0;
                    err_code_d = 2'd0;
                    err_filt_d = 2'd0;
                    err_adr_d  = 2'd0;
                    cnt_d      = '0;
                    widx_d     = 2'd0;
                    filt_d     = first_s[1:0];
                    first_d    = first_s[1:0];
                    state_d    = first_s[2] ? S_BSRST : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_W'(CLR_LEN - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (widx_q == 2'd3) begin
                    widx_d = 2'd0;
                    if (next_s[2]) begin
                        state_d = S_RD;
                        filt_d  = first_q;
                    end else begin
                        filt_d  = next_s[1:0];
                    end
                end else begin
                    widx_d = widx_q + 2'd1;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (coeff_valid[filt_q]) begin
                    if (coeff_rdata != snap_q[widx_q]) begin
                        state_d    = S_FAIL;
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        err_filt_d = filt_q;
                        err_adr_d  = widx_q;
                    end else if (widx_q == 2'd3) begin
                        widx_d = 2'd0;
                        if (next_s[2]) begin
                            state_d = S_BSRST;
                        end else begin
                            filt_d  = next_s[1:0];
                            state_d = S_RD;
                        end
                    end else begin
                        widx_d  = widx_q + 2'd1;
                        state_d = S_RD;
                    end
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    state_d    = S_FAIL;
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    err_filt_d = filt_q;
                    err_adr_d  = widx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BSRST: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LEN - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port is a flop aligned with state_q.
    always_comb begin
        busy_d         = !(state_d inside {S_IDLE, S_DONE, S_FAIL});
        done_d         = (state_d == S_DONE) || (state_d == S_FAIL);
        bsum_reset_d   = (state_d == S_BSRST);
        coeff_areset_d = (state_d == S_CLEAR);
        coeff_we_d     = (state_d == S_WRITE) ? (4'd1 << filt_d) : 4'd0;
        coeff_read_d   = (state_d == S_RD);
        coeff_adr_d    = (state_d inside {S_WRITE, S_RD, S_WAIT}) ? widx_d : 2'd0;
        coeff_data_d   = (state_d == S_WRITE) ? snap_d[widx_d] : 64'd0;
        valid_gate_d   = valid_gate_q;
        if ((state_q == S_IDLE) && start) begin
            valid_gate_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            valid_gate_d = 1'b1;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign err_filt     = err_filt_q;
    assign err_adr      = err_adr_q;
    assign valid_gate   = valid_gate_q;
    assign bsum_reset   = bsum_reset_q;
    assign coeff_areset = coeff_areset_q;
    assign coeff_we     = coeff_we_q;
    assign coeff_adr    = coeff_adr_q;
    assign coeff_data   = coeff_data_q;
    assign coeff_read   = coeff_read_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Scoreboarded bench: a reference plan of coefficient-port events is queued per sequence and
// popped by a monitor; a behavioural filter model answers reads with configurable latency/faults.
module tb_fir_coeff_sequencer;
    localparam int CLR_LEN    = 4;
    localparam int RD_TIMEOUT = 16;
    localparam int SETTLE_LEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        stage_we;
    logic [1:0]  stage_adr;
    logic [63:0] stage_data;
    logic        start;
    logic [3:0]  filt_mask;
    logic        busy, done, err, valid_gate, bsum_reset, coeff_areset, coeff_read;
    logic [1:0]  err_code, err_filt, err_adr, coeff_adr;
    logic [3:0]  coeff_we;
    logic [63:0] coeff_data;
    logic [3:0]  coeff_valid;
    logic [63:0] coeff_rdata;

    fir_coeff_sequencer #(.CLR_LEN(CLR_LEN), .RD_TIMEOUT(RD_TIMEOUT), .SETTLE_LEN(SETTLE_LEN)) dut (
        .clk(clk), .reset(reset), .stage_we(stage_we), .stage_adr(stage_adr),
        .stage_data(stage_data), .start(start), .filt_mask(filt_mask), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .err_filt(err_filt), .err_adr(err_adr),
        .valid_gate(valid_gate), .bsum_reset(bsum_reset), .coeff_areset(coeff_areset),
        .coeff_we(coeff_we), .coeff_adr(coeff_adr), .coeff_data(coeff_data),
        .coeff_read(coeff_read), .coeff_valid(coeff_valid), .coeff_rdata(coeff_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ar;
        logic [3:0]  we;
        logic        rd;
        logic [1:0]  adr;
        logic [63:0] data;
        logic        bs;
        logic        dn;
        logic        er;
        logic [1:0]  code;
        logic [1:0]  efilt;
        logic [1:0]  eadr;
        logic        gate;
        logic        busy;
    } ev_t;

    ev_t         exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [63:0] stage_m [4];
    logic [63:0] mem [4][4];
    int          pair_filt[$];
    int          rd_idx = 0;
    int          rd_lat = 1;
    int          dead_filt = -1;
    int          bad_filt = -1;
    int          bad_adr = -1;
    int          done_cnt = 0, wr_cnt = 0, rd_cnt = 0, bs_cnt = 0;
    int          done_cyc = 0, bs_cyc = 0, rd_cyc = 0, start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic ev_t seq_ev();
        ev_t e;
        e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    // Reference plan: clear, write every (filter, word) in order, read back in order, re-arm.
    task automatic plan(input logic [3:0] m, input int lat, input int dead, input int bf, input int ba);
        ev_t e;
        bit  stop;
        rd_lat = lat; dead_filt = dead; bad_filt = bf; bad_adr = ba;
        rd_idx = 0;
        pair_filt.delete();
        stop = 0;
        if (m != 4'd0) begin
            for (int i = 0; i < CLR_LEN; i++) begin
                e = seq_ev(); e.ar = 1'b1; exp_q.push_back(e);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int a = 0; a < 4; a++) begin
                    e = seq_ev(); e.we = 4'(1 << k); e.adr = 2'(a); e.data = stage_m[a];
                    exp_q.push_back(e);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < 4; a++) begin
                if (m[k] && !stop) begin
                    pair_filt.push_back(k);
                    e = seq_ev(); e.rd = 1'b1; e.adr = 2'(a); exp_q.push_back(e);
                    if (k == dead || (k == bf && a == ba)) begin
                        e = '0; e.dn = 1'b1; e.er = 1'b1;
                        e.code = (k == dead) ? 2'd2 : 2'd1;
                        e.efilt = 2'(k); e.eadr = 2'(a);
                        exp_q.push_back(e);
                        stop = 1;
                    end
                end
            end
        end
        if (!stop) begin
            e = seq_ev(); e.bs = 1'b1; exp_q.push_back(e);
            e = '0; e.dn = 1'b1; e.gate = 1'b1; exp_q.push_back(e);
        end
    endtask

    task automatic begin_seq(input logic [3:0] m, input int lat, input int dead, input int bf, input int ba);
        plan(m, lat, dead, bf, ba);
        wr_cnt = 0; rd_cnt = 0; bs_cnt = 0;
        start = 1'b1; filt_mask = m; start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        n_chk++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles, expected a done pulse", budget);
        end
    endtask

    task automatic run_seq(input logic [3:0] m, input int lat, input int dead, input int bf, input int ba);
        int d0;
        d0 = done_cnt;
        begin_seq(m, lat, dead, bf, ba);
        wait_done(d0, 400);
        check_int("queue_drained", exp_q.size(), 0);
    endtask

    task automatic stage_write(input logic [1:0] a, input logic [63:0] d);
        stage_we = 1'b1; stage_adr = a; stage_data = d;
        tick();
        stage_we = 1'b0;
        stage_m[a] = d;
    endtask

    // Filter model: stores writes, answers reads after rd_lat cycles, sprinkles other-filter valids.
    initial begin
        logic [3:0]  nv;
        logic [1:0]  pa;
        bit          pend;
        int          wait_n, pk, cur_k;
        pend = 0; wait_n = 0; pk = 0; cur_k = 0; pa = 2'd0;
        coeff_valid = 4'd0; coeff_rdata = 64'd0;
        forever begin
            @(negedge clk);
            nv = 4'($urandom) & ~(4'd1 << cur_k);
            coeff_rdata = {$urandom, $urandom};
            if (pend) begin
                if (wait_n == 0) begin
                    pend = 0;
                    nv[pk] = 1'b1;
                    coeff_rdata = mem[pk][pa];
                    if (pk == bad_filt && int'(pa) == bad_adr) coeff_rdata = ~coeff_rdata;
                end else begin
                    wait_n--;
                end
            end
            coeff_valid = nv;
            if (reset) begin
                pend = 0;
            end else begin
                if (coeff_areset) begin
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++) mem[i][j] = 64'd0;
                end
                for (int i = 0; i < 4; i++)
                    if (coeff_we[i]) mem[i][coeff_adr] = coeff_data;
                if (coeff_read) begin
                    pk = (rd_idx < pair_filt.size()) ? pair_filt[rd_idx] : 0;
                    rd_idx++;
                    cur_k = pk; pa = coeff_adr; wait_n = rd_lat - 1;
                    pend = (pk != dead_filt);
                end
            end
        end
    end

    // Monitor: every cycle with port activity or a done pulse must match the next planned event.
    initial begin
        ev_t o, e;
        forever begin
            @(negedge clk);
            if (!reset && (coeff_areset || coeff_we != 4'd0 || coeff_read || bsum_reset || done)) begin
                o = '0;
                o.ar = coeff_areset; o.we = coeff_we; o.rd = coeff_read; o.bs = bsum_reset;
                o.dn = done; o.er = err; o.code = err_code; o.efilt = err_filt; o.eadr = err_adr;
                o.gate = valid_gate; o.busy = busy;
                if (coeff_we != 4'd0 || coeff_read) o.adr = coeff_adr;
                if (coeff_we != 4'd0) begin o.data = coeff_data; wr_cnt++; end
                if (coeff_read) begin rd_cnt++; rd_cyc = cyc; end
                if (bsum_reset) begin bs_cnt++; bs_cyc = cyc; end
                if (done) begin done_cnt++; done_cyc = cyc; end
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h, expected no activity", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL port_event: got %h, expected %h", o, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [3:0] m;
        reset = 1'b1; stage_we = 1'b0; stage_adr = 2'd0; stage_data = 64'd0;
        start = 1'b0; filt_mask = 4'd0;
        for (int i = 0; i < 4; i++) stage_m[i] = 64'd0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'({err, err_code, err_filt, err_adr}), 64'd0);
        check("rst_gate", 64'(valid_gate), 64'd1);
        check("rst_bsum", 64'(bsum_reset), 64'd0);
        check("rst_port", 64'({coeff_areset, coeff_we, coeff_adr, coeff_read}), 64'd0);
        check("rst_data", coeff_data, 64'd0);
        reset = 1'b0;
        tick();

        // Full mask, known words, 1-cycle read response
        stage_write(2'd0, 64'h1111_1111_1111_1111);
        stage_write(2'd1, 64'h2222_2222_2222_2222);
        stage_write(2'd2, 64'h3333_3333_3333_3333);
        stage_write(2'd3, 64'h4444_4444_4444_4444);
        run_seq(4'hF, 1, -1, -1, -1);
        check_int("full_latency", done_cyc - start_cyc, 1 + CLR_LEN + 16 + 32 + 1 + SETTLE_LEN + 1 - 1);
        check_int("bsum_to_done", done_cyc - bs_cyc, SETTLE_LEN + 1);
        check_int("full_writes", wr_cnt, 16);
        check_int("full_reads", rd_cnt, 16);
        check_int("full_bsum", bs_cnt, 1);
        tick();
        check("gate_after_done", 64'(valid_gate), 64'd1);

        // Partial mask
        run_seq(4'b0101, $urandom_range(1, 3), -1, -1, -1);
        check_int("partial_writes", wr_cnt, 8);
        check_int("partial_reads", rd_cnt, 8);

        // Corrupted readback on filter 2 word 3
        for (int i = 0; i < 4; i++) stage_write(2'(i), {$urandom, $urandom});
        run_seq(4'hF, 1, -1, 2, 3);
        check_int("mismatch_bsum", bs_cnt, 0);
        repeat (5) tick();
        check("mismatch_err", 64'({err, err_code, err_filt, err_adr}), 64'({1'b1, 2'd1, 2'd2, 2'd3}));
        check("mismatch_gate", 64'(valid_gate), 64'd0);

        // Filter 1 never answers
        run_seq(4'hF, 1, 1, -1, -1);
        check_int("timeout_delay", done_cyc - rd_cyc, RD_TIMEOUT + 1);
        check_int("timeout_reads", rd_cnt, 5);
        check("timeout_err", 64'({err, err_code, err_filt, err_adr}), 64'({1'b1, 2'd2, 2'd1, 2'd0}));

        // start and stage_we while busy are ignored
        for (int i = 0; i < 4; i++) stage_write(2'(i), {$urandom, $urandom});
        d0 = done_cnt;
        begin_seq(4'hF, 2, -1, -1, -1);
        repeat (10) tick();
        start = 1'b1; filt_mask = 4'b0010;
        stage_we = 1'b1; stage_adr = 2'd1; stage_data = {$urandom, $urandom};
        tick();
        start = 1'b0; stage_we = 1'b0;
        wait_done(d0, 400);
        d0 = done_cnt;
        repeat (20) tick();
        check_int("no_restart", done_cnt - d0, 0);
        check_int("busy_queue", exp_q.size(), 0);

        // Same-cycle start and staging write: sequence sees the old word
        stage_we = 1'b1; stage_adr = 2'd2; stage_data = {$urandom, $urandom};
        d0 = done_cnt;
        begin_seq(4'b0001, 1, -1, -1, -1);
        stage_we = 1'b0;
        stage_m[2] = stage_data;
        wait_done(d0, 400);
        check_int("same_cycle_queue", exp_q.size(), 0);
        run_seq(4'b0100, 1, -1, -1, -1);

        // Empty mask: straight to bsum_reset and settle
        run_seq(4'd0, 1, -1, -1, -1);
        check_int("mask0_latency", done_cyc - start_cyc, SETTLE_LEN + 2);
        check_int("mask0_writes", wr_cnt + rd_cnt, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) stage_write(2'(i), {$urandom, $urandom});
            m = 4'($urandom_range(0, 15));
            run_seq(m, $urandom_range(1, 4), -1, -1, -1);
        end

        // Reset in the middle of WRITE
        for (int i = 0; i < 4; i++) stage_write(2'(i), {$urandom, $urandom});
        begin_seq(4'hF, 1, -1, -1, -1);
        for (int n = 0; n < 50 && wr_cnt < 3; n++) tick();
        check_int("reached_write", (wr_cnt >= 3) ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        check("midrst_we", 64'(coeff_we), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_gate", 64'(valid_gate), 64'd1);
        check("midrst_ctl", 64'({coeff_areset, coeff_read, done, bsum_reset}), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) stage_m[i] = 64'd0;
        tick();
        run_seq(4'hF, 1, -1, -1, -1);
        check("post_rst_err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_coeff_sequencer.md
Name: fir_coeff_sequencer

Overview:
- Sequences coefficient reloads into the four-lane FIR trigger filter through its coefficient port (areset / we / adr / data / read).
- Stages four 64-bit coefficient words from a host register interface, clears and writes a selected subset of the four internal filters, then reads back and verifies every word.
- Gates the trigger's valid_in during the reload, pulses bsum_reset afterwards, and holds the gate closed while the filter settles, so no TOT fires on half-loaded coefficients.
- Sits between the slow-control register bank and the trigger block.

Parameters:
- CLR_LEN, 4: cycles coeff_areset is held high.
- RD_TIMEOUT, 16: max cycles waiting for coeff_out_valid per readback.
- SETTLE_LEN, 32: cycles the valid gate stays low after the bsum_reset pulse.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stage_we  in  1  write a staging word.
- stage_adr  in  2  staging word index.
- stage_data  in  64  staging word value.
- start  in  1  one-cycle request to begin a reload.
- filt_mask  in  4  filters to load; sampled on the accepted start.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  sticky; last sequence failed.
- err_code  out  2  0 none, 1 readback mismatch, 2 readback timeout.
- err_filt  out  2  filter index of the first failure.
- err_adr  out  2  word index of the first failure.
- valid_gate  out  1  ANDed externally with the trigger valid_in.
- bsum_reset  out  1  to the trigger bsum_reset.
- coeff_areset  out  1  to coeff_in_areset.
- coeff_we  out  4  to coeff_in_we.
- coeff_adr  out  2  to coeff_in_adr.
- coeff_data  out  64  to coeff_in_data.
- coeff_read  out  1  to coeff_in_read.
- coeff_valid  in  4  from coeff_out_valid.
- coeff_rdata  in  64  from coeff_out_data.

Behaviour:

Reset values:
- All outputs are 0 except valid_gate, which resets to 1.
- Staging registers reset to 0.
- FSM resets to IDLE.

Staging register:
- stage_we writes stage_data to stage[stage_adr] on the next edge, only when busy=0.
- stage_we is ignored while busy=1.

Start:
- start is accepted only in IDLE.
- On acceptance: latch filt_mask, clear err/err_code/err_filt/err_adr, set busy=1 and valid_gate=0 on the next edge.
- If the latched mask is 0, go directly to BSRST; no coefficient port activity occurs.

FSM states:
- CLEAR: coeff_areset=1 for exactly CLR_LEN cycles, then WRITE.
- WRITE: one cycle per (filter, word) pair.
  - Order: filter 0..3, skipping masked-off filters; within each filter, adr 0..3.
  - Each cycle drives coeff_we as one-hot on the filter, coeff_adr=adr, coeff_data=stage[adr].
  - Writes are back-to-back; a full mask takes 16 cycles. Then VERIFY.
- VERIFY, per (filter k, adr), same order as WRITE:
  - Issue one cycle with coeff_read=1 and coeff_adr=adr. Then wait; coeff_read=0 while waiting.
  - In the cycle coeff_valid[k]=1, compare coeff_rdata with stage[adr].
  - valid bits of other filters are ignored.
  - If coeff_valid[k] has not appeared within RD_TIMEOUT cycles after the read cycle, go to FAIL with err_code=2.
  - On mismatch, go to FAIL with err_code=1.
  - err_filt and err_adr record the failing pair.
  - After all pairs match, go to BSRST.
- BSRST: bsum_reset=1 for one cycle, then SETTLE.
- SETTLE: count SETTLE_LEN cycles, then DONE.
- DONE: valid_gate=1, busy=0, done=1 for one cycle, then IDLE.
- FAIL: err=1, done=1 for one cycle, busy=0, then IDLE.
  - valid_gate stays 0 until the next successful sequence or reset; the trigger must not run on bad coefficients.

Output timing:
- All coefficient-port outputs are registered.
- coeff_we, coeff_read and coeff_areset are 0 in every state not listed above for them.

Boundary conditions:
- start while busy: ignored; no queuing.
- start and stage_we in the same IDLE cycle: the staging write lands, but the sequence uses the staging contents before that write.
- Staging is frozen while busy.
- reset mid-sequence: everything returns to reset values on the next edge. coeff_we, coeff_read and coeff_areset deassert and valid_gate goes to 1. The filter contents are then undefined and the host must restart.

Latency:
- Full-mask successful sequence with a 1-cycle read response: 1 (start) + CLR_LEN + 16 + 16×2 + 1 + SETTLE_LEN + 1 cycles.

Test Plan:
1. Stage words 0x1111.., 0x2222.., 0x3333.., 0x4444..; start with mask=0xF; model returns written data with 1-cycle latency -> 4 areset cycles; 16 writes with we=0001,0001,..,1000; 16 reads; single bsum_reset pulse; valid_gate low for the whole sequence, high after SETTLE_LEN; done pulse; err=0.
2. mask=0b0101 -> writes and reads only for filters 0 and 2 (8 each); we never equals 0010 or 1000.
3. Model corrupts filter 2 adr 3 readback -> FAIL; err=1, err_code=1, err_filt=2, err_adr=3; no bsum_reset pulse; valid_gate stays 0.
4. Model never asserts coeff_valid[1] -> timeout exactly RD_TIMEOUT cycles after the read; err_code=2, err_filt=1, err_adr=0.
5. start again while busy, and stage_we while busy -> no restart and staging unchanged (check via readback data). mask=0 start -> done within 1+1+SETTLE_LEN+1 cycles with no coefficient port activity.
6. Assert reset during WRITE -> next edge: coeff_we=0, busy=0, valid_gate=1, staging=0. A fresh sequence then completes cleanly.
